// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer with DMG falling-edge tick semantics.
// Define GB_TIMER_DELAYED_RELOAD_EN for the 4-clk OVF + RELOAD sequence.
module gb_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        wren_i,
  output logic [7:0]  data_o,
  output logic        hit_o,
  output logic        irq_timer_o
);

  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  tima, tima_nxt;
  logic [7:0]  tma, tma_nxt;
  logic [2:0]  tac, tac_nxt;
  logic        tick_q, tick_nxt, fall;
  logic        irq_nxt;
  logic        sel_div, sel_tima, sel_tma, sel_tac;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  function automatic logic tap_bit(
    input logic [2:0]  t,
    input logic [15:0] c
  );
    logic b;
    case (t[1:0])
      2'b00:   b = c[9];
      2'b01:   b = c[3];
      2'b10:   b = c[5];
      default: b = c[7];
    endcase
    return t[2] & b;
  endfunction

  assign sel_div  = (addr_i == 16'hFF04);
  assign sel_tima = (addr_i == 16'hFF05);
  assign sel_tma  = (addr_i == 16'hFF06);
  assign sel_tac  = (addr_i == 16'hFF07);
  assign hit_o    = sel_div | sel_tima | sel_tma | sel_tac;

  assign wr_div  = wren_i & sel_div;
  assign wr_tima = wren_i & sel_tima;
  assign wr_tma  = wren_i & sel_tma;
  assign wr_tac  = wren_i & sel_tac;

  assign cnt_nxt = wr_div ? 16'h0000 : cnt + 16'h0001;
  assign tac_nxt = wr_tac ? data_i[2:0] : tac;
  assign tma_nxt = wr_tma ? data_i : tma;

  // Tick is judged on post-edge state so DIV/TAC writes glitch TIMA.
  assign tick_nxt = tap_bit(tac_nxt, cnt_nxt);
  assign fall     = tick_q & ~tick_nxt;

  // Register read mux.
  always_comb begin
    data_o = 8'hFF;
    unique case (1'b1)
      sel_div:  data_o = cnt[15:8];
      sel_tima: data_o = tima;
      sel_tma:  data_o = tma;
      sel_tac:  data_o = {5'b11111, tac};
      default:  data_o = 8'hFF;
    endcase
  end

  // Divider, control registers and tick history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 16'h0000;
      tac    <= 3'b000;
      tma    <= 8'h00;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tac    <= tac_nxt;
      tma    <= tma_nxt;
      tick_q <= tick_nxt;
    end
  end

`ifdef GB_TIMER_DELAYED_RELOAD_EN

  typedef enum logic [1:0] {
    RUN,
    OVF,
    RELOAD
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] dly, dly_nxt;

  // Overflow sequencing: RUN -> OVF (4 clks at 0x00) -> RELOAD (irq).
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly;
    tima_nxt  = tima;
    irq_nxt   = 1'b0;
    unique case (state)
      RUN: begin
        if (wr_tima) begin
          tima_nxt = data_i;
        end else if (fall) begin
          if (tima == 8'hFF) begin
            tima_nxt  = 8'h00;
            state_nxt = OVF;
            dly_nxt   = 2'd0;
          end else begin
            tima_nxt = tima + 8'h01;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_nxt  = data_i;
          state_nxt = RUN;
        end else if (dly == 2'd3) begin
          tima_nxt  = tma;
          irq_nxt   = ~irq_timer_o;
          state_nxt = RELOAD;
        end else begin
          dly_nxt = dly + 2'd1;
          if (fall) tima_nxt = tima + 8'h01;
        end
      end
      RELOAD: begin
        state_nxt = RUN;
        if (wr_tma) begin
          tima_nxt = data_i;
        end else if (fall) begin
          tima_nxt = tima + 8'h01;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // FSM and counter state; reset aborts any pending reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      dly         <= 2'd0;
      tima        <= 8'h00;
      irq_timer_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      dly         <= dly_nxt;
      tima        <= tima_nxt;
      irq_timer_o <= irq_nxt;
    end
  end

`else

  // Immediate reload: TMA lands on the overflow edge, irq next cycle.
  always_comb begin
    tima_nxt = tima;
    irq_nxt  = 1'b0;
    if (wr_tima) begin
      tima_nxt = data_i;
    end else if (fall) begin
      if (tima == 8'hFF) begin
        tima_nxt = tma;
        irq_nxt  = ~irq_timer_o;
      end else begin
        tima_nxt = tima + 8'h01;
      end
    end
  end

  // Counter and irq registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tima        <= 8'h00;
      irq_timer_o <= 1'b0;
    end else begin
      tima        <= tima_nxt;
      irq_timer_o <= irq_nxt;
    end
  end

`endif

endmodule
